// File: rtl/vram_pkg.sv
// Shared definitions for the video RAM fill engine: geometry, color
// encodings, fill FSM states and the fill range check.
package vram_pkg;

  localparam int ADDR_W     = 16;
  localparam int COLOR_W    = 3;
  localparam int VRAM_DEPTH = 2400;

  // 3-bit {R,G,B} color encodings used by the VGA instruction path
  localparam logic [COLOR_W-1:0] COLOR_BLACK   = 3'd0;
  localparam logic [COLOR_W-1:0] COLOR_BLUE    = 3'd1;
  localparam logic [COLOR_W-1:0] COLOR_GREEN   = 3'd2;
  localparam logic [COLOR_W-1:0] COLOR_CYAN    = 3'd3;
  localparam logic [COLOR_W-1:0] COLOR_RED     = 3'd4;
  localparam logic [COLOR_W-1:0] COLOR_MAGENTA = 3'd5;
  localparam logic [COLOR_W-1:0] COLOR_YELLOW  = 3'd6;
  localparam logic [COLOR_W-1:0] COLOR_WHITE   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

  // A fill is legal when the range is non-empty and lies inside video RAM.
  // Arguments are zero-extended addresses, so the comparisons are unsigned.
  function automatic logic fill_range_ok(input logic [31:0] first,
                                         input logic [31:0] last,
                                         input logic [31:0] depth);
    return (first <= last) && (last < depth);
  endfunction

endpackage

// File: rtl/vram_fill_controller.sv
// Hardware fill engine and write-port arbiter for the single video RAM
// write port. CPU pixel writes always win; the fill engine writes one
// pixel per free cycle from first to last inclusive.
module vram_fill_controller
  import vram_pkg::*;
#(
  parameter int ADDR_W     = vram_pkg::ADDR_W,
  parameter int COLOR_W    = vram_pkg::COLOR_W,
  parameter int VRAM_DEPTH = vram_pkg::VRAM_DEPTH
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iCpuWe,
  input  logic [ADDR_W-1:0]  iCpuAddr,
  input  logic [COLOR_W-1:0] iCpuColor,
  input  logic               iFillStart,
  input  logic [ADDR_W-1:0]  iFillFirst,
  input  logic [ADDR_W-1:0]  iFillLast,
  input  logic [COLOR_W-1:0] iFillColor,
  input  logic               iFillAbort,
  output logic               oFillBusy,
  output logic               oFillDone,
  output logic               oFillError,
  output logic               oVramWe,
  output logic [ADDR_W-1:0]  oVramAddr,
  output logic [COLOR_W-1:0] oVramData
);

  fill_state_e        state_r, state_s;
  logic [ADDR_W-1:0]  cur_r, cur_s;
  logic [ADDR_W-1:0]  last_r, last_s;
  logic [COLOR_W-1:0] color_r, color_s;
  logic               vram_we_r, vram_we_s;
  logic [ADDR_W-1:0]  vram_addr_r, vram_addr_s;
  logic [COLOR_W-1:0] vram_data_r, vram_data_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               error_r, error_s;
  logic               range_ok_s;

  assign range_ok_s = fill_range_ok(32'(iFillFirst), 32'(iFillLast), 32'(VRAM_DEPTH));

  // Next-state, fill counter and write-port arbitration
  always_comb begin
    state_s     = state_r;
    cur_s       = cur_r;
    last_s      = last_r;
    color_s     = color_r;
    vram_we_s   = 1'b0;
    vram_addr_s = vram_addr_r;
    vram_data_s = vram_data_r;
    done_s      = 1'b0;
    error_s     = 1'b0;

    // CPU writes own the port whenever they are present, in every state
    if (iCpuWe) begin
      vram_we_s   = 1'b1;
      vram_addr_s = iCpuAddr;
      vram_data_s = iCpuColor;
    end else begin
      vram_we_s   = 1'b0;
    end

    case (state_r)
      IDLE: begin
        if (iFillStart) begin
          if (range_ok_s) begin
            state_s = FILL;
            cur_s   = iFillFirst;
            last_s  = iFillLast;
            color_s = iFillColor;
          end else begin
            error_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end

      FILL: begin
        if (iFillAbort) begin
          // Abort leaves only the CPU write (if any) at this edge
          state_s = IDLE;
        end else if (!iCpuWe) begin
          vram_we_s   = 1'b1;
          vram_addr_s = cur_r;
          vram_data_s = color_r;
          if (cur_r == last_r) begin
            state_s = DONE;
            done_s  = 1'b1;
          end else begin
            cur_s = cur_r + ADDR_W'(1);
          end
        end else begin
          // Preempted by the CPU: the fill pointer holds
          cur_s = cur_r;
        end
      end

      DONE: begin
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign busy_s = (state_s != IDLE);

  // State, fill registers and registered outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r     <= IDLE;
      cur_r       <= '0;
      last_r      <= '0;
      color_r     <= '0;
      vram_we_r   <= 1'b0;
      vram_addr_r <= '0;
      vram_data_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      cur_r       <= cur_s;
      last_r      <= last_s;
      color_r     <= color_s;
      vram_we_r   <= vram_we_s;
      vram_addr_r <= vram_addr_s;
      vram_data_r <= vram_data_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      error_r     <= error_s;
    end
  end

  assign oFillBusy  = busy_r;
  assign oFillDone  = done_r;
  assign oFillError = error_r;
  assign oVramWe    = vram_we_r;
  assign oVramAddr  = vram_addr_r;
  assign oVramData  = vram_data_r;

endmodule

// File: tb/tb_vram_fill_controller.sv
// Directed bench for vram_fill_controller. Expected video RAM writes are
// queued as stimulus is driven and compared as the DUT emits them.
module tb_vram_fill_controller;
  import vram_pkg::*;

  typedef struct packed {
    logic [15:0] addr;
    logic [2:0]  data;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        Reset;
  logic        iCpuWe;
  logic [15:0] iCpuAddr;
  logic [2:0]  iCpuColor;
  logic        iFillStart;
  logic [15:0] iFillFirst;
  logic [15:0] iFillLast;
  logic [2:0]  iFillColor;
  logic        iFillAbort;
  logic        oFillBusy, oFillDone, oFillError, oVramWe;
  logic [15:0] oVramAddr;
  logic [2:0]  oVramData;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc_cnt = 0;
  int   done_cyc = 0;
  int   start_cyc = 0;
  logic mon_en = 1'b0;
  int   lat;

  vram_fill_controller dut (
    .Clock(clk), .Reset(Reset),
    .iCpuWe(iCpuWe), .iCpuAddr(iCpuAddr), .iCpuColor(iCpuColor),
    .iFillStart(iFillStart), .iFillFirst(iFillFirst), .iFillLast(iFillLast),
    .iFillColor(iFillColor), .iFillAbort(iFillAbort),
    .oFillBusy(oFillBusy), .oFillDone(oFillDone), .oFillError(oFillError),
    .oVramWe(oVramWe), .oVramAddr(oVramAddr), .oVramData(oVramData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write the DUT emits must match the queue head
  always @(negedge clk) begin
    if (mon_en) begin
      if (oVramWe === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(oVramAddr), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 32'(oVramAddr), 32'(mon_e.addr));
          chk("wr_data", 32'(oVramData), 32'(mon_e.data));
          chk("wr_done", 32'(oFillDone), 32'(mon_e.done));
        end
      end else begin
        chk("idle_no_done", 32'(oFillDone), 32'd0);
      end
      if (oFillDone === 1'b1) done_cyc = cyc_cnt;
    end
  end

  task automatic push(input int addr, input logic [2:0] data, input logic done);
    exp_t e;
    e.addr = 16'(addr);
    e.data = data;
    e.done = done;
    exp_q.push_back(e);
  endtask

  // stop_kind: 0 none, 1 abort when cur reaches stop_addr, 2 reset there
  task automatic run_fill(input int first, input int last, input logic [2:0] color,
                          input logic [63:0] cpu_mask, input int stop_addr,
                          input int stop_kind, input int restart_cyc,
                          input logic start_cpu, output int latency);
    int cur;
    int cyc;
    int cpu_i;
    latency    = -1;
    iFillStart = 1'b1;
    iFillFirst = 16'(first);
    iFillLast  = 16'(last);
    iFillColor = color;
    if (start_cpu) begin
      iCpuWe = 1'b1; iCpuAddr = 16'd2100; iCpuColor = COLOR_CYAN;
      push(2100, COLOR_CYAN, 1'b0);
    end else begin
      iCpuWe = 1'b0;
    end
    @(posedge clk); #1;
    iFillStart = 1'b0; iCpuWe = 1'b0;
    start_cyc = cyc_cnt;
    chk("busy_after_start", 32'(oFillBusy), 32'd1);
    chk("no_err_valid_start", 32'(oFillError), 32'd0);
    cur = first; cyc = 0; cpu_i = 0;
    while (cur <= last) begin
      if (stop_kind != 0 && cur == stop_addr) begin
        if (stop_kind == 1) iFillAbort = 1'b1;
        else Reset = 1'b1;
        @(posedge clk); #1;
        iFillAbort = 1'b0; Reset = 1'b0;
        chk("stop_busy", 32'(oFillBusy), 32'd0);
        chk("stop_done", 32'(oFillDone), 32'd0);
        chk("stop_we", 32'(oVramWe), 32'd0);
        chk("stop_err", 32'(oFillError), 32'd0);
        if (stop_kind == 2) begin
          chk("rst_addr", 32'(oVramAddr), 32'd0);
          chk("rst_data", 32'(oVramData), 32'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("stop_busy_later", 32'(oFillBusy), 32'd0);
        return;
      end
      if (cyc == restart_cyc) begin
        iFillStart = 1'b1; iFillFirst = 16'd5; iFillLast = 16'd6; iFillColor = COLOR_WHITE;
      end
      if (cyc < 64 && cpu_mask[cyc]) begin
        iCpuWe = 1'b1; iCpuAddr = 16'(2000 + cpu_i); iCpuColor = COLOR_BLUE;
        push(2000 + cpu_i, COLOR_BLUE, 1'b0);
        cpu_i++;
      end else begin
        push(cur, color, cur == last);
        cur++;
      end
      @(posedge clk); #1;
      iFillStart = 1'b0; iCpuWe = 1'b0;
      if (cyc == restart_cyc) chk("busy_start_no_err", 32'(oFillError), 32'd0);
      cyc++;
    end
    @(negedge clk); #1;
    latency = done_cyc - start_cyc;
    chk("busy_in_done", 32'(oFillBusy), 32'd1);
    @(posedge clk); #1;
    chk("busy_drop", 32'(oFillBusy), 32'd0);
    chk("done_one_cycle", 32'(oFillDone), 32'd0);
  endtask

  task automatic bad_start(input int first, input int last);
    iFillStart = 1'b1; iFillFirst = 16'(first); iFillLast = 16'(last); iFillColor = COLOR_RED;
    @(posedge clk); #1;
    iFillStart = 1'b0;
    chk("err_pulse", 32'(oFillError), 32'd1);
    chk("err_busy", 32'(oFillBusy), 32'd0);
    chk("err_no_we", 32'(oVramWe), 32'd0);
    @(posedge clk); #1;
    chk("err_one_cycle", 32'(oFillError), 32'd0);
    chk("err_busy_after", 32'(oFillBusy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; iCpuWe = 1'b0; iCpuAddr = 16'd0; iCpuColor = 3'd0;
    iFillStart = 1'b0; iFillFirst = 16'd0; iFillLast = 16'd0;
    iFillColor = 3'd0; iFillAbort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    Reset = 1'b0;
    chk("rst_we", 32'(oVramWe), 32'd0);
    chk("rst_addr0", 32'(oVramAddr), 32'd0);
    chk("rst_data0", 32'(oVramData), 32'd0);
    chk("rst_busy", 32'(oFillBusy), 32'd0);
    chk("rst_done", 32'(oFillDone), 32'd0);
    chk("rst_err", 32'(oFillError), 32'd0);
    mon_en = 1'b1;

    // CPU pass-through in IDLE, then hold of addr/data
    iCpuWe = 1'b1; iCpuAddr = 16'd100; iCpuColor = COLOR_YELLOW;
    push(100, COLOR_YELLOW, 1'b0);
    @(posedge clk); #1;
    iCpuWe = 1'b0;
    @(posedge clk); #1;
    chk("hold_we", 32'(oVramWe), 32'd0);
    chk("hold_addr", 32'(oVramAddr), 32'd100);
    chk("hold_data", 32'(oVramData), 32'(COLOR_YELLOW));

    // Uncontended 600-pixel fill
    run_fill(0, 599, COLOR_GREEN, 64'd0, -1, 0, -1, 1'b0, lat);
    chk("lat_uncontended", 32'(lat), 32'd600);

    // Fill preempted by three CPU writes
    run_fill(600, 1199, COLOR_RED, (64'd1 << 5) | (64'd1 << 10) | (64'd1 << 20),
             -1, 0, -1, 1'b0, lat);
    chk("lat_contended", 32'(lat), 32'd603);

    // Rejected starts
    bad_start(10, 5);
    bad_start(0, 2400);

    // Abort after the write to 1850, then a single-pixel fill at the top
    run_fill(1800, 2399, COLOR_WHITE, 64'd0, 1851, 1, -1, 1'b0, lat);
    run_fill(2399, 2399, COLOR_MAGENTA, 64'd0, -1, 0, -1, 1'b0, lat);
    chk("lat_single", 32'(lat), 32'd1);

    // Reset mid-fill
    run_fill(0, 599, COLOR_GREEN, 64'd0, 10, 2, -1, 1'b0, lat);

    // Start with a coincident CPU write, plus an ignored start while busy
    run_fill(100, 199, COLOR_CYAN, 64'd0, -1, 0, 7, 1'b1, lat);
    chk("lat_busy_start", 32'(lat), 32'd100);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
